// File: rtl/pong_pkg.sv
// Shared encodings and default playfield geometry for the pong game controller.
// All coordinates are 11-bit pixel positions; arithmetic on them is done at 12 bits.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // POS means rightwards on x and downwards on y.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int unsigned COORD_W          = 11;
    localparam int unsigned SCORE_W          = 6;

    localparam int unsigned DEF_SCREEN_W     = 800;
    localparam int unsigned DEF_SCREEN_H     = 600;
    localparam int unsigned DEF_BALL_SIZE    = 8;
    localparam int unsigned DEF_PAD_W        = 8;
    localparam int unsigned DEF_PAD_H        = 64;
    localparam int unsigned DEF_PAD_L_X      = 16;
    localparam int unsigned DEF_PAD_R_X      = 776;
    localparam int unsigned DEF_BALL_SPEED   = 2;
    localparam int unsigned DEF_PAD_SPEED    = 4;
    localparam int unsigned DEF_SERVE_FRAMES = 60;
    localparam int unsigned DEF_WIN_SCORE    = 15;

endpackage

// File: rtl/paddle_mover.sv
// One paddle: moves its top edge by PAD_SPEED per enabled frame, clamped to
// the playfield. Both or neither button held leaves the paddle where it is.
module paddle_mover
    import pong_pkg::*;
#(
    parameter int unsigned PAD_H     = DEF_PAD_H,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned PAD_SPEED = DEF_PAD_SPEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               down,
    output logic [COORD_W-1:0] y
);

    localparam logic [11:0]        Y_MAX  = 12'(SCREEN_H - PAD_H);
    localparam logic [11:0]        SPD    = 12'(PAD_SPEED);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'((SCREEN_H - PAD_H) / 2);

    logic [11:0]        y_wide;
    logic [COORD_W-1:0] y_next;

    assign y_wide = {1'b0, y};

    // NOTE: y_next gets its hold value before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        y_next = y;
        if (en && up && !down) begin
            y_next = (y_wide <= SPD) ? '0 : COORD_W'(y_wide - SPD);
        end else if (en && down && !up) begin
            y_next = (y_wide + SPD >= Y_MAX) ? COORD_W'(Y_MAX) : COORD_W'(y_wide + SPD);
        end
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= Y_INIT;
        end else begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/pong_engine.sv
// Frame-rate pong controller: game FSM, ball motion with paddle/wall handling,
// and scoring. State only advances on an unpaused frame_tick.
module pong_engine
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
    parameter int unsigned PAD_W        = DEF_PAD_W,
    parameter int unsigned PAD_H        = DEF_PAD_H,
    parameter int unsigned PAD_L_X      = DEF_PAD_L_X,
    parameter int unsigned PAD_R_X      = DEF_PAD_R_X,
    parameter int unsigned BALL_SPEED   = DEF_BALL_SPEED,
    parameter int unsigned PAD_SPEED    = DEF_PAD_SPEED,
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               btn_l_up,
    input  logic               btn_l_dn,
    input  logic               btn_r_up,
    input  logic               btn_r_dn,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] pad_l_y,
    output logic [COORD_W-1:0] pad_r_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic [1:0]         state
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [11:0] SPD    = 12'(BALL_SPEED);
    localparam logic [11:0] BALL12 = 12'(BALL_SIZE);
    localparam logic [11:0] PADH12 = 12'(PAD_H);
    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] L_FACE = 12'(PAD_L_X + PAD_W);
    localparam logic [11:0] R_FACE = 12'(PAD_R_X - BALL_SIZE);

    localparam logic [COORD_W-1:0] BALL_X0 = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] BALL_Y0 = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0]   SERVE_N = CNT_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_N   = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_n;
    dir_t               dx_q, dx_n, dy_q, dy_n, serve_q, serve_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
    logic [COORD_W-1:0] ball_x_n, ball_y_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n, score_l_inc, score_r_inc;

    logic               tick, move_en;
    logic [11:0]        x_wide, y_wide, pl_wide, pr_wide;
    logic               overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;
    logic [COORD_W-1:0] x_step, y_step;
    dir_t               dx_step, dy_step;

    assign tick    = frame_tick && !pause;
    assign move_en = tick && (state_q == ST_SERVE || state_q == ST_PLAY);
    assign state   = state_q;

    paddle_mover #(.PAD_H(PAD_H), .SCREEN_H(SCREEN_H), .PAD_SPEED(PAD_SPEED)) u_pad_l (
        .clk  (clk),
        .rst  (rst),
        .en   (move_en),
        .up   (btn_l_up),
        .down (btn_l_dn),
        .y    (pad_l_y)
    );

    paddle_mover #(.PAD_H(PAD_H), .SCREEN_H(SCREEN_H), .PAD_SPEED(PAD_SPEED)) u_pad_r (
        .clk  (clk),
        .rst  (rst),
        .en   (move_en),
        .up   (btn_r_up),
        .down (btn_r_dn),
        .y    (pad_r_y)
    );

    // Hit tests read the registered (pre-tick) paddle positions.
    assign x_wide  = {1'b0, ball_x};
    assign y_wide  = {1'b0, ball_y};
    assign pl_wide = {1'b0, pad_l_y};
    assign pr_wide = {1'b0, pad_r_y};

    assign overlap_l = (y_wide + BALL12 > pl_wide) && (y_wide < pl_wide + PADH12);
    assign overlap_r = (y_wide + BALL12 > pr_wide) && (y_wide < pr_wide + PADH12);

    assign hit_l  = (dx_q == DIR_NEG) && (x_wide <= L_FACE + SPD) && (x_wide >= L_FACE) && overlap_l;
    assign hit_r  = (dx_q == DIR_POS) && (x_wide + SPD >= R_FACE) && (x_wide <= R_FACE) && overlap_r;
    assign miss_l = (dx_q == DIR_NEG) && !hit_l && (x_wide <= SPD);
    assign miss_r = (dx_q == DIR_POS) && !hit_r && (x_wide + SPD >= X_MAX);

    always_comb begin
        y_step  = ball_y;
        dy_step = dy_q;
        if (dy_q == DIR_NEG) begin
            if (y_wide <= SPD) begin
                y_step  = '0;
                dy_step = DIR_POS;
            end else begin
                y_step = COORD_W'(y_wide - SPD);
            end
        end else if (y_wide + SPD >= Y_MAX) begin
            y_step  = COORD_W'(Y_MAX);
            dy_step = DIR_NEG;
        end else begin
            y_step = COORD_W'(y_wide + SPD);
        end
    end

    // On a miss the x step value is discarded, so the left-side wrap is harmless.
    always_comb begin
        x_step  = ball_x;
        dx_step = dx_q;
        if (hit_l) begin
            x_step  = COORD_W'(L_FACE);
            dx_step = DIR_POS;
        end else if (hit_r) begin
            x_step  = COORD_W'(R_FACE);
            dx_step = DIR_NEG;
        end else if (dx_q == DIR_NEG) begin
            x_step = COORD_W'(x_wide - SPD);
        end else begin
            x_step = COORD_W'(x_wide + SPD);
        end
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign score_l_inc = score_l + 1'b1;
    assign score_r_inc = score_r + 1'b1;

    always_comb begin
        state_n   = state_q;
        dx_n      = dx_q;
        dy_n      = dy_q;
        serve_n   = serve_q;
        cnt_n     = cnt_q;
        ball_x_n  = ball_x;
        ball_y_n  = ball_y;
        score_l_n = score_l;
        score_r_n = score_r;
        unique case (state_q)
            ST_IDLE: begin
                ball_x_n = BALL_X0;
                ball_y_n = BALL_Y0;
                if (start) begin
                    state_n = ST_SERVE;
                    cnt_n   = '0;
                end
            end
            ST_SERVE: begin
                ball_x_n = BALL_X0;
                ball_y_n = BALL_Y0;
                if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == SERVE_N) begin
                        state_n = ST_PLAY;
                        dx_n    = serve_q;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (miss_l || miss_r) begin
                        ball_x_n = BALL_X0;
                        ball_y_n = BALL_Y0;
                        cnt_n    = '0;
                        if (miss_l) begin
                            score_r_n = score_r_inc;
                            serve_n   = DIR_NEG;
                            state_n   = (score_r_inc == WIN_N) ? ST_OVER : ST_SERVE;
                        end else begin
                            score_l_n = score_l_inc;
                            serve_n   = DIR_POS;
                            state_n   = (score_l_inc == WIN_N) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        ball_x_n = x_step;
                        dx_n     = dx_step;
                        ball_y_n = y_step;
                        dy_n     = dy_step;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    cnt_n     = '0;
                    state_n   = ST_SERVE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
            serve_q   <= DIR_POS;
            cnt_q     <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_n;
            dx_q      <= dx_n;
            dy_q      <= dy_n;
            serve_q   <= serve_n;
            cnt_q     <= cnt_n;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            game_over <= (state_n == ST_OVER);
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: walks one scripted game whose ball trajectory
// is hand-computed, covering serve timing, paddle clamps, bounces, hits and misses.
module tb_pong_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [10:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [5:0]  score_l, score_r;
    logic        game_over;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    pong_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .pause      (pause),
        .btn_l_up   (btn_l_up),
        .btn_l_dn   (btn_l_dn),
        .btn_r_up   (btn_r_up),
        .btn_r_dn   (btn_r_dn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, ".x"}, 12'(ball_x), 12'(x));
        check({tag, ".y"}, 12'(ball_y), 12'(y));
    endtask

    // Each tick is a one-cycle strobe; outputs are sampled on the following negedge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic start_with_tick();
        @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_state", 12'(state), 12'd0);
        check_ball("rst_ball", 396, 296);
        check("rst_pad_l", 12'(pad_l_y), 12'd268);
        check("rst_pad_r", 12'(pad_r_y), 12'd268);
        check("rst_score_l", 12'(score_l), 12'd0);
        check("rst_score_r", 12'(score_r), 12'd0);
        check("rst_game_over", 12'(game_over), 12'd0);

        // Idle ignores ticks and buttons.
        btn_l_up = 1'b1;
        ticks(5);
        btn_l_up = 1'b0;
        check("idle_state", 12'(state), 12'd0);
        check_ball("idle_ball", 396, 296);
        check("idle_pad_l", 12'(pad_l_y), 12'd268);

        // Start plus tick in one cycle: the tick is not counted.
        start_with_tick();
        check("start_state", 12'(state), 12'd1);
        ticks(59);
        check("serve59_state", 12'(state), 12'd1);
        ticks(1);
        check("serve60_state", 12'(state), 12'd2);
        check_ball("serve60_ball", 396, 296);
        ticks(1);
        check_ball("play_t1", 398, 298);

        // Pause swallows ticks completely.
        pause = 1'b1;
        btn_l_dn = 1'b1;
        ticks(10);
        pause = 1'b0;
        btn_l_dn = 1'b0;
        check_ball("pause_ball", 398, 298);
        check("pause_pad_l", 12'(pad_l_y), 12'd268);
        check("pause_state", 12'(state), 12'd2);

        // Left paddle up to the top clamp (t = 2..71).
        btn_l_up = 1'b1;
        ticks(66);
        check("pad_l_4", 12'(pad_l_y), 12'd4);
        ticks(1);
        check("pad_l_clamp", 12'(pad_l_y), 12'd0);
        ticks(3);
        check("pad_l_stay", 12'(pad_l_y), 12'd0);

        // All buttons held (t = 72): both paddles hold.
        btn_l_dn = 1'b1; btn_r_up = 1'b1; btn_r_dn = 1'b1;
        ticks(1);
        btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
        check("both_pad_l", 12'(pad_l_y), 12'd0);
        check("both_pad_r", 12'(pad_r_y), 12'd268);

        // Right paddle down 50 steps (t = 73..122).
        btn_r_dn = 1'b1;
        ticks(50);
        btn_r_dn = 1'b0;
        check("pad_r_468", 12'(pad_r_y), 12'd468);
        check_ball("play_t122", 640, 540);

        // Bottom bounce at t=148, right paddle hit at t=186.
        ticks(63);
        check_ball("play_t185", 766, 518);
        ticks(1);
        check_ball("hit_r_t186", 768, 516);
        ticks(1);
        check_ball("hit_r_t187", 766, 514);

        // Top wall: y=2 moving up goes to 0, then back to 2.
        ticks(256);
        check_ball("top_t443", 254, 2);
        ticks(1);
        check_ball("top_t444", 252, 0);
        ticks(1);
        check_ball("top_t445", 250, 2);

        // Left paddle at 0 does not cover y=226: left miss.
        ticks(124);
        check_ball("pre_miss", 2, 250);
        ticks(1);
        check("miss1_score_r", 12'(score_r), 12'd1);
        check("miss1_score_l", 12'(score_l), 12'd0);
        check("miss1_state", 12'(state), 12'd1);
        check_ball("miss1_ball", 396, 296);

        // Serve 2: paddles move during serve.
        btn_l_dn = 1'b1; btn_r_up = 1'b1;
        ticks(60);
        btn_r_up = 1'b0;
        check("serve2_state", 12'(state), 12'd2);
        check("serve2_pad_l", 12'(pad_l_y), 12'd240);
        check("serve2_pad_r", 12'(pad_r_y), 12'd228);
        ticks(1);
        check_ball("serve2_s1", 394, 298);
        ticks(59);
        btn_l_dn = 1'b0;
        check("serve2_pad_l_480", 12'(pad_l_y), 12'd480);

        // Left paddle hit at x=26 -> 24 -> 26.
        ticks(125);
        check_ball("hit_l_s185", 26, 518);
        ticks(1);
        check_ball("hit_l_s186", 24, 516);
        ticks(1);
        check_ball("hit_l_s187", 26, 514);

        // Right paddle at 228 returns the ball, left paddle at 480 misses it.
        ticks(371);
        check_ball("hit_r2_s558", 768, 228);
        ticks(383);
        check_ball("pre_miss2", 2, 190);
        ticks(1);
        check("miss2_score_r", 12'(score_r), 12'd2);
        check("miss2_state", 12'(state), 12'd1);

        // Serves 3..15 all end in a left miss; the last one ends the game.
        for (int k = 3; k <= 15; k++) begin
            btn_l_up = (k == 3);
            ticks(60);
            btn_l_up = 1'b0;
            check("serve_k_state", 12'(state), 12'd2);
            ticks(198);
            check("miss_k_score_r", 12'(score_r), 12'(k));
            check("miss_k_state", 12'(state), (k == 15) ? 12'd3 : 12'd1);
        end
        check("over_pad_l", 12'(pad_l_y), 12'd240);
        check("over_game_over", 12'(game_over), 12'd1);
        check("over_score_l", 12'(score_l), 12'd0);

        // OVER is frozen.
        btn_r_dn = 1'b1;
        ticks(3);
        btn_r_dn = 1'b0;
        check("over_hold_state", 12'(state), 12'd3);
        check("over_hold_score", 12'(score_r), 12'd15);
        check("over_hold_pad_r", 12'(pad_r_y), 12'd228);

        // Restart from OVER with a coincident tick.
        start_with_tick();
        check("restart_state", 12'(state), 12'd1);
        check("restart_score_r", 12'(score_r), 12'd0);
        check("restart_game_over", 12'(game_over), 12'd0);
        ticks(59);
        check("restart59_state", 12'(state), 12'd1);
        ticks(1);
        check("restart60_state", 12'(state), 12'd2);
        ticks(1);
        check_ball("restart_s1", 394, 298);

        // Reset mid-play with a coincident tick.
        ticks(5);
        @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
        check("rst2_state", 12'(state), 12'd0);
        check_ball("rst2_ball", 396, 296);
        check("rst2_pad_l", 12'(pad_l_y), 12'd268);
        check("rst2_pad_r", 12'(pad_r_y), 12'd268);
        check("rst2_score_r", 12'(score_r), 12'd0);
        check("rst2_game_over", 12'(game_over), 12'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_engine.md
# pong_engine

Frame-rate game controller for the ball-and-paddle design: owns ball position/direction, both paddle positions and both scores. It sequences the game (idle, serve, play, game over) and drives the coordinate and score inputs of the video encoder. State advances only on a one-cycle `frame_tick` strobe issued during vertical blanking, so the encoder never sees a mid-frame coordinate change.

## Interface
Parameters:
- `SCREEN_W`, 800: playfield width, px
- `SCREEN_H`, 600: playfield height, px
- `BALL_SIZE`, 8: ball edge, px
- `PAD_W`, 8: paddle width, px
- `PAD_H`, 64: paddle height, px
- `PAD_L_X`, 16: left paddle left edge
- `PAD_R_X`, 776: right paddle left edge
- `BALL_SPEED`, 2: ball step per frame, each axis
- `PAD_SPEED`, 4: paddle step per frame
- `SERVE_FRAMES`, 60: frames of serve delay
- `WIN_SCORE`, 15: score that ends the game (must be ≤ 63)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `frame_tick`  in  1  one-cycle strobe per frame, in vertical blanking
- `start`  in  1  level; starts the game from IDLE or OVER
- `pause`  in  1  level; while high, frame ticks are ignored
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn`  in  1 each  paddle controls (pre-debounced)
- `ball_x`, `ball_y`  out  11  ball top-left corner
- `pad_l_y`, `pad_r_y`  out  11  paddle top edges
- `score_l`, `score_r`  out  6  scores
- `game_over`  out  1  high in OVER
- `state`  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

## Operation
- Reset: state IDLE; ball at (396,296), i.e. ((W−BALL)/2, (H−BALL)/2); both paddles at 268, i.e. (H−PAD_H)/2; scores 0; serve direction right, dy down; frame counter 0; `game_over` 0.
- IDLE: ball held centred, paddles frozen. `start` high → SERVE and counter cleared.
- SERVE: ball centred, paddles move. Each tick increments the counter. On the tick that brings the counter to SERVE_FRAMES → PLAY, with dx = serve direction and dy unchanged.
- PLAY, per tick: both paddles move, then the ball moves, using the pre-tick paddle positions for the hit test.
- Paddle move: up only → y − PAD_SPEED, clamped at 0. Down only → y + PAD_SPEED, clamped at H−PAD_H. Both or neither pressed → hold.
- Ball y: moving up and y ≤ BALL_SPEED → y=0 and dy becomes down. Moving down and y+BALL_SPEED ≥ H−BALL_SIZE → y=H−BALL_SIZE and dy becomes up. Otherwise y ± BALL_SPEED.
- Left-paddle hit: moving left, x−BALL_SPEED ≤ PAD_L_X+PAD_W, x ≥ PAD_L_X+PAD_W, and the ball overlaps the paddle (ball_y+BALL_SIZE > pad_l_y and ball_y < pad_l_y+PAD_H) → x=PAD_L_X+PAD_W, dx becomes right.
- Right-paddle hit: mirror of the left case, against PAD_R_X−BALL_SIZE.
- Miss: moving left and x ≤ BALL_SPEED (no hit) → score_r+1, serve direction set left, SERVE, counter cleared, ball recentred. Right-side miss: x+BALL_SPEED ≥ W−BALL_SIZE → score_l+1, serve direction set right.
- If an incremented score equals WIN_SCORE → OVER instead of SERVE.
- OVER: all positions frozen, `game_over`=1. `start` → scores cleared, SERVE.
- All comparisons use 12-bit unsigned arithmetic so no intermediate value wraps.

## Timing
- All outputs are registered. A tick in cycle N produces new values visible in cycle N+1 (latency 1). Outputs are constant between ticks.
- `pause` high during a tick: the tick is ignored entirely (no motion, no count).
- `start` and `frame_tick` in the same cycle in IDLE/OVER: the state change takes effect and the tick is not applied. The first counted tick is the next one.
- Ball-moves-onto-paddle and wall bounce in the same tick: both axes resolve independently in that cycle.
- A miss and a wall bounce in the same tick: the miss wins; the y update is discarded.
- `rst` overrides everything, including a same-cycle tick, and restores the reset values the following cycle.

## Structure
- Package `pong_pkg`: state encodings, direction encodings, default geometry constants.
- Sub-module `paddle_mover` (clk, rst, tick enable, up, down, y out; parameters PAD_H, SCREEN_H, PAD_SPEED), instantiated twice.
- Ball, score and FSM logic stay in `pong_engine`.

## Test plan
- Reset, then 5 ticks with no `start` → ball (396,296), paddles 268, state 0.
- `start`, 60 ticks → state 2 and ball unmoved; 1 more tick → ball_x=398, ball_y=298.
- `btn_l_up` held for 70 PLAY ticks → pad_l_y reaches 0 and stays there. Both buttons held → no change.
- Ball at y=1 moving up, one tick → ball_y=0 and the next tick gives 2. Ball at x=26 moving left, pad_l_y aligned, one tick → x=24, then x=26.
- Ball at x=2 moving left with the paddle away → score_r=1, state 1, ball centred, next serve moves left. Repeat to score_r=15 → state 3, `game_over`=1.
- `pause` high across 10 ticks → outputs unchanged. `rst` asserted mid-PLAY → reset values next cycle.
